ecg_uart_packetizer: RTL and testbench

- Downstream consumer of the MCP3202 SPI master's 12-bit sample output and its data-valid level.
- Captures each new ECG sample on the rising edge of dv and buffers it in a small FIFO.
- Serialises each sample as a 2-byte 8N1 UART frame to the host for plotting/logging.
- Decouples the 500 sps ADC cadence from UART transmit timing and flags lost samples.

---
 rtl/ecg_uart_packetizer_if.sv | 8 +
 rtl/ecg_uart_packetizer.sv | 192 +++++++++++++++++++
 tb/tb_ecg_uart_packetizer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecg_uart_packetizer_if.sv
// Sample bus from the MCP3202 SPI master: 12-bit ADC word plus its data-valid level.
interface ecg_uart_packetizer_if;
    logic [11:0] data;
    logic        dv;

    modport master (output data, output dv);
    modport slave  (input  data, input  dv);
endinterface

// File: rtl/ecg_uart_packetizer.sv
// Buffers ECG samples in a small FIFO and sends each one as a 2-byte 8N1 UART frame.
// Optional ECG_PKT_SEQ_EN embeds a 2-bit frame sequence number in bit 6 of both bytes.
module ecg_uart_packetizer #(
    parameter int FCLK       = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ecg_uart_packetizer_if.slave          adc,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CPB   = FCLK / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CPB_M1 = CNT_W'(CPB - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_e;

    state_e            state_q, state_d;
    logic              tx_q, tx_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic              byte_idx_q, byte_idx_d;
    logic [5:0]        word_lo_q, word_lo_d;

    logic              dv_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              overflow_q;
    logic [11:0]       mem_q [FIFO_DEPTH];

    logic              push, pop, wr_en, full, empty, baud_done;
    logic [11:0]       rd_data;
    logic              seq_hi, seq_lo;

    assign push    = adc.dv & ~dv_q;
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // A full FIFO still accepts a sample when the same edge pops one.
    assign wr_en   = push & (~full | pop);
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= adc.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dv_q <= adc.dv;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

`ifdef ECG_PKT_SEQ_EN
    logic [1:0] seq_q;
    logic       frame_seq_lo_q;

    // byte1 must carry the sequence value captured at LOAD, not the incremented one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q          <= 2'd0;
            frame_seq_lo_q <= 1'b0;
        end else if (state_q == LOAD) begin
            seq_q          <= seq_q + 2'd1;
            frame_seq_lo_q <= seq_q[0];
        end
    end

    assign seq_hi = seq_q[1];
    assign seq_lo = frame_seq_lo_q;
`else
    assign seq_hi = 1'b0;
    assign seq_lo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            byte_idx_q <= 1'b0;
            word_lo_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_q     <= baud_d;
            byte_idx_q <= byte_idx_d;
            word_lo_q  <= word_lo_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx_q lines up with state_q.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_d     = baud_q;
        byte_idx_d = byte_idx_q;
        word_lo_d  = word_lo_q;
        pop        = 1'b0;
        baud_done  = (baud_q == CPB_M1);

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty) state_d = LOAD;
            end
            LOAD: begin
                pop        = 1'b1;
                word_lo_d  = rd_data[5:0];
                byte_idx_d = 1'b0;
                shift_d    = {1'b1, seq_hi, rd_data[11:6]};
                bit_cnt_d  = '0;
                baud_d     = '0;
                tx_d       = 1'b0;
                state_d    = START;
            end
            START: begin
                tx_d   = 1'b0;
                baud_d = baud_done ? '0 : baud_q + CNT_W'(1);
                if (baud_done) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                tx_d   = shift_q[0];
                baud_d = baud_done ? '0 : baud_q + CNT_W'(1);
                if (baud_done) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_d   = 1'b1;
                baud_d = baud_done ? '0 : baud_q + CNT_W'(1);
                if (baud_done) begin
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        shift_d    = {1'b0, seq_lo, word_lo_q};
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else if (!empty) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) | (count_q != '0);
    assign overflow   = overflow_q;
    assign fifo_level = count_q;
endmodule

// File: tb/tb_ecg_uart_packetizer.sv
// Directed bench for ecg_uart_packetizer at 10 clocks per bit; a line monitor decodes the UART bytes.
`timescale 1ns/1ps
module tb_ecg_uart_packetizer;
    localparam int CPB    = 10;
    localparam int BIT_NS = CPB * 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx, busy, overflow;
    logic [4:0] fifo_level;

    ecg_uart_packetizer_if bus ();

    ecg_uart_packetizer #(
        .FCLK       (1000),
        .BAUD       (100),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc        (bus.slave),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rst_cnt = 0;
    always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int push_cyc = 0;
    logic [7:0] rx_q[$];

    // Samples mid-bit; a byte cut short by reset or with a bad stop bit is discarded.
    initial begin : monitor
        int         snap;
        logic [7:0] b;
        forever begin
            @(negedge tx);
            if (rst_n === 1'b1) begin
                snap = rst_cnt;
                #(BIT_NS / 2 + 3);
                for (int i = 0; i < 8; i++) begin
                    #(BIT_NS);
                    b[i] = tx;
                end
                #(BIT_NS);
                if (snap == rst_cnt && rst_n === 1'b1 && tx === 1'b1) rx_q.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp[$]);
        check({tag, "_nbytes"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx_q.size()) check($sformatf("%s_b%0d", tag, i), rx_q[i], exp[i]);
        end
        $display("%s: received %0d bytes, expected %0d", tag, rx_q.size(), exp.size());
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        bus.dv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] d, input int hold);
        bus.data = d;
        bus.dv   = 1'b1;
        @(posedge clk);
        #1;
        push_cyc = cyc;
        repeat (hold - 1) @(posedge clk);
        if (hold > 1) #1;
        bus.dv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] enc(input logic [11:0] s, input int seqn);
        logic [15:0] r;
        r = {2'b10, s[11:6], 2'b00, s[5:0]};
`ifdef ECG_PKT_SEQ_EN
        r[14] = seqn[1];
        r[6]  = seqn[0];
`else
        if (seqn < 0) r = '0;
`endif
        return r;
    endfunction

    initial begin
        int          e;
        logic [4:0]  peak;
        logic [7:0]  exp[$];
        logic [15:0] w;

        bus.data = '0;
        bus.dv   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", fifo_level, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single sample 0xABC, dv held high for 1000 cycles.
        bus.data = 12'hABC;
        bus.dv   = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        check("t1_level_after_push", fifo_level, 1);
        check("t1_tx_edge1", tx, 1);
        @(posedge clk);
        #1;
        check("t1_tx_load", tx, 1);
        @(posedge clk);
        #1;
        check("t1_tx_fall", tx, 0);
        check("t1_level_popped", fifo_level, 0);
        check("t1_busy_frame", busy, 1);
        wait_until(e + 201);
        check("t1_busy_last", busy, 1);
        wait_until(e + 202);
        check("t1_busy_done", busy, 0);
        wait_until(e + 1000);
        bus.dv = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t1_tx_idle", tx, 1);
        check("t1_level_end", fifo_level, 0);
        exp = '{8'hAA, 8'h3C};
        check_rx("t1_single", exp);

        // Three pulses 10 clocks apart.
        do_reset();
        push(12'h000, 1);
        e = push_cyc;
        wait_until(e + 9);
        push(12'hFFF, 1);
        wait_until(e + 19);
        push(12'h800, 1);
        peak = fifo_level;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            #1;
            if (fifo_level > peak) peak = fifo_level;
        end
        check("t2_peak", peak, 2);
`ifdef ECG_PKT_SEQ_EN
        exp = '{8'h80, 8'h00, 8'hBF, 8'h7F, 8'hE0, 8'h00};
`else
        exp = '{8'h80, 8'h00, 8'hBF, 8'h3F, 8'hA0, 8'h00};
`endif
        check_rx("t2_b2b", exp);

        // Overflow: 18 back-to-back pushes; the first is popped, the 18th is dropped.
        do_reset();
        exp.delete();
        for (int n = 1; n <= 18; n++) begin
            push(12'(n * 247 + 3), 1);
            if (n == 17) begin
                check("t3_level_17", fifo_level, 16);
                check("t3_ovf_17", overflow, 0);
            end
            if (n <= 17) begin
                w = enc(12'(n * 247 + 3), (n - 1) % 4);
                exp.push_back(w[15:8]);
                exp.push_back(w[7:0]);
            end
        end
        check("t3_level_18", fifo_level, 16);
        check("t3_ovf_18", overflow, 1);
        repeat (3600) @(posedge clk);
        #1;
        check("t3_ovf_sticky", overflow, 1);
        check("t3_level_drained", fifo_level, 0);
        check_rx("t3_overflow", exp);
        do_reset();
        check("t3_ovf_cleared", overflow, 0);

        // Full FIFO with a push on the exact LOAD cycle.
        for (int n = 1; n <= 17; n++) begin
            push(12'(n * 5), 1);
            if (n == 1) e = push_cyc;
        end
        check("t4_level_full", fifo_level, 16);
        wait_until(e + 202);
        check("t4_level_at_load", fifo_level, 16);
        bus.data = 12'h123;
        bus.dv   = 1'b1;
        @(posedge clk);
        #1;
        bus.dv = 1'b0;
        check("t4_level_after", fifo_level, 16);
        check("t4_ovf", overflow, 0);

        // Reset asserted during DATA bit 3 of byte0 (0x80 -> bit3 is 0).
        do_reset();
        push(12'h000, 1);
        e = push_cyc;
        wait_until(e + 46);
        check("t5_tx_bit3", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_tx_async", tx, 1);
        check("t5_level_async", fifo_level, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("t5_level", fifo_level, 0);
        check("t5_busy", busy, 0);
        check("t5_nbytes", rx_q.size(), 0);

        // dv already high when reset releases gives exactly one push.
        rst_n    = 1'b0;
        bus.data = 12'h555;
        bus.dv   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete();
        @(posedge clk);
        #1;
        check("t6_level", fifo_level, 1);
        repeat (300) @(posedge clk);
        #1;
        bus.dv = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        exp = '{8'h95, 8'h15};
        check_rx("t6_dv_at_reset", exp);

`ifdef ECG_PKT_SEQ_EN
        // Five zero samples: sequence 0,1,2,3,0 split across bit 6 of each byte.
        do_reset();
        for (int n = 0; n < 5; n++) push(12'h000, 1);
        repeat (1200) @(posedge clk);
        #1;
        exp = '{8'h80, 8'h00, 8'h80, 8'h40, 8'hC0, 8'h00, 8'hC0, 8'h40, 8'h80, 8'h00};
        check_rx("t7_seq", exp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
